// File: rtl/cpu_exc_pkg.sv
// Shared exception definitions: ExcCodes, handler entry address, sequencer states.
// Also provides the victim-PC to EPC conversion used at exception entry.
package cpu_exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
    localparam int          DEF_NSTAGE     = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_ERET     = 2'd2,
        ST_REDIRECT = 2'd3
    } seq_state_t;

    // A delay-slot victim restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] aligned;
        aligned = {pc[31:2], 2'b00};
        return bd ? (aligned - 32'd4) : aligned;
    endfunction

endpackage

// File: rtl/exc_victim_sel.sv
// Picks the oldest occupied stage (index 0 = M is oldest) as interrupt victim.
// Purely combinational; found=0 when every stage holds a bubble (PC 0).
module exc_victim_sel
    import cpu_exc_pkg::*;
#(
    parameter int N = DEF_NSTAGE
) (
    input  logic [N-1:0][31:0] stage_pc,
    input  logic [N-1:0]       stage_bd,
    output logic [31:0]        victim_pc,
    output logic               victim_bd,
    output logic               found
);

    // Scan youngest to oldest so the oldest occupied stage is the last write.
    always_comb begin
        victim_pc = '0;
        victim_bd = 1'b0;
        found     = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (stage_pc[i] != '0) begin
                victim_pc = stage_pc[i];
                victim_bd = stage_bd[i];
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt/ERET sequencer: commits to CP0, flushes, redirects fetch.
// Latency: 2 cycles trigger->redirect; mem_busy holds triggers off in RUN.
// Optional EXC_SEQ_STATS_EN adds saturating exc_count/int_count outputs.
module exc_sequencer
    import cpu_exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter int          NSTAGE     = DEF_NSTAGE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  exc_m,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [31:0] pc_e,
    input  logic [31:0] pc_m,
    input  logic        bd_d,
    input  logic        bd_e,
    input  logic        bd_m,
    input  logic        eret_m,
    input  logic        int_pending,
    input  logic        exl,
    input  logic [31:0] epc,
    input  logic        mem_busy,
    output logic        cp0_req,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_epc,
    output logic        cp0_bd,
    output logic        cp0_eret,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
`ifdef EXC_SEQ_STATS_EN
    output logic [15:0] exc_count,
    output logic [15:0] int_count,
`endif
    output logic        busy
);

    seq_state_t state;

    logic [NSTAGE-1:0][31:0] stage_pc;
    logic [NSTAGE-1:0]       stage_bd;
    logic [31:0]             victim_pc;
    logic                    victim_bd;
    logic                    victim_found;

    // F has no delay-slot flag: an instruction there is never known to be in one.
    assign stage_pc = {pc_f, pc_d, pc_e, pc_m};
    assign stage_bd = {1'b0, bd_d, bd_e, bd_m};

    exc_victim_sel #(.N(NSTAGE)) u_victim_sel (
        .stage_pc  (stage_pc),
        .stage_bd  (stage_bd),
        .victim_pc (victim_pc),
        .victim_bd (victim_bd),
        .found     (victim_found)
    );

    logic take_exc, take_int, take_eret;

    assign take_exc  = !mem_busy && !exl && (exc_m != EXC_INT);
    assign take_int  = !mem_busy && !exl && int_pending && victim_found;
    assign take_eret = !mem_busy && eret_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_RUN;
            cp0_req        <= 1'b0;
            cp0_exccode    <= '0;
            cp0_epc        <= '0;
            cp0_bd         <= 1'b0;
            cp0_eret       <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            cp0_req        <= 1'b0;
            cp0_eret       <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (take_exc) begin
                        state       <= ST_COMMIT;
                        cp0_req     <= 1'b1;
                        flush       <= 1'b1;
                        cp0_exccode <= exc_m;
                        cp0_epc     <= epc_of(pc_m, bd_m);
                        cp0_bd      <= bd_m;
                    end else if (take_int) begin
                        state       <= ST_COMMIT;
                        cp0_req     <= 1'b1;
                        flush       <= 1'b1;
                        cp0_exccode <= EXC_INT;
                        cp0_epc     <= epc_of(victim_pc, victim_bd);
                        cp0_bd      <= victim_bd;
                    end else if (take_eret) begin
                        state    <= ST_ERET;
                        cp0_eret <= 1'b1;
                        flush    <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state          <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                    flush          <= 1'b1;
                    redirect_pc    <= HANDLER_PC;
                end
                ST_ERET: begin
                    // EPC is read while CP0 clears EXL, so the return target is current.
                    state          <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                    flush          <= 1'b1;
                    redirect_pc    <= epc;
                end
                ST_REDIRECT: state <= ST_RUN;
                default:     state <= ST_RUN;
            endcase
        end
    end

    assign busy = (state != ST_RUN);

`ifdef EXC_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_count <= '0;
            int_count <= '0;
        end else if (state == ST_COMMIT) begin
            if (cp0_exccode != EXC_INT) begin
                if (exc_count != 16'hFFFF) exc_count <= exc_count + 16'd1;
            end else begin
                if (int_count != 16'hFFFF) int_count <= int_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
Exception/interrupt sequencer for the 5-stage MIPS pipeline. It sits between the pipeline stage registers and the CP0 register block. It picks the victim instruction, orders the commit into CP0 (EXL/Cause/EPC update), flushes the pipeline and redirects the PC to the handler, or back to EPC on ERET. It is the only agent allowed to raise CP0 exception-entry and ERET requests.

Parameters:
HANDLER_PC, 32'h0000_4180, exception/interrupt entry address
NSTAGE, 4, number of tracked stages (F, D, E, M); fixed at 4, provided for package consistency

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
exc_m  input  5  ExcCode carried by the M-stage instruction; 0 = none
pc_f / pc_d / pc_e / pc_m  input  32 each  stage PCs; 0 = bubble
bd_d / bd_e / bd_m  input  1 each  stage instruction sits in a branch delay slot
eret_m  input  1  M-stage instruction is ERET
int_pending  input  1  from CP0: |(HWInt & IM) & IE
exl  input  1  CP0 SR.EXL
epc  input  32  CP0 EPC value
mem_busy  input  1  M-stage bus access in flight; commit must wait
cp0_req  output  1  one-cycle pulse: CP0 performs exception entry
cp0_exccode  output  5  Cause.ExcCode value for cp0_req
cp0_epc  output  32  EPC value for cp0_req, word-aligned
cp0_bd  output  1  Cause.BD value for cp0_req
cp0_eret  output  1  one-cycle pulse: CP0 clears EXL
flush  output  1  kill all F/D/E/M stage registers this cycle
redirect_valid  output  1  load PC from redirect_pc
redirect_pc  output  32  next fetch address
busy  output  1  FSM is not in RUN

Behaviour:
- Reset: state=RUN. All outputs are 0, and redirect_pc=0. A reset asserted in any state aborts the sequence; no redirect follows.
- FSM states: RUN, COMMIT, ERET, REDIRECT. The state register and all outputs are registered.
- RUN, trigger evaluation each cycle, only when mem_busy=0. Priority order:
  1. exl=0 and exc_m!=0: exception; victim is the M stage.
  2. exl=0 and int_pending: interrupt with code 0; victim is the oldest non-zero PC in the order M, E, D, F.
  3. eret_m=1, regardless of exl.
  4. If none of these applies, stay in RUN.
- Exceptions in F, D or E are not acted on. They take effect when the instruction reaches M.
- If exl=1, exc_m and int_pending are ignored and the FSM stays in RUN.
- If all stage PCs are 0 during an interrupt, the interrupt is deferred and the FSM stays in RUN.
- Victim to EPC: if the victim has bd=1, cp0_epc = {pc[31:2],2'b00} - 4 and cp0_bd=1. Otherwise cp0_epc = {pc[31:2],2'b00} and cp0_bd=0.
- RUN -> COMMIT (exception or interrupt):
  - In COMMIT: cp0_req=1, flush=1, with cp0_exccode/cp0_epc/cp0_bd latched from the trigger cycle.
  - Next state is REDIRECT with redirect_pc=HANDLER_PC.
- RUN -> ERET:
  - In ERET: cp0_eret=1, flush=1, and epc is sampled into redirect_pc.
  - Next state is REDIRECT.
- REDIRECT: redirect_valid=1 and flush=1 for one cycle, then RUN.
- Total latency is 2 cycles from trigger to the handler fetch.
- No new trigger is accepted until the FSM is back in RUN.
- Simultaneous events:
  - exc_m together with eret_m: the exception wins.
  - int_pending together with eret_m (exl=0): the interrupt wins, victim is M, and EPC is the ERET PC.
- mem_busy=1 holds the FSM in RUN. Pipeline stalling during this time is the pipeline's job.
- busy = (state != RUN).

Optional Feature:
- Macro EXC_SEQ_STATS_EN.
- When defined, add output ports exc_count[15:0] and int_count[15:0].
  - Each counter increments in COMMIT, selected by whether the code is non-zero or zero.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- When undefined, these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package cpu_exc_pkg holds:
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12
  - HANDLER_PC default
  - the FSM state encoding
- One combinational sub-module, exc_victim_sel: takes the stage PCs and bd bits; returns the victim PC, victim BD and found flag.

Test Plan:
- RUN, exc_m=12, pc_m=32'h3010, bd_m=0, exl=0 -> next cycle cp0_req=1, code 12, cp0_epc=32'h3010, flush=1; following cycle redirect_valid=1, redirect_pc=32'h4180; then busy=0.
- exc_m=4, pc_m=32'h3024, bd_m=1 -> cp0_epc=32'h3020, cp0_bd=1.
- int_pending=1, pc_m=0, pc_e=0, pc_d=32'h3040 -> cp0_exccode=0, cp0_epc=32'h3040; with all PCs 0, no cp0_req until one PC becomes non-zero.
- exl=1, exc_m=10 -> no cp0_req; eret_m=1, epc=32'h3044 -> cp0_eret pulse, then redirect_pc=32'h3044.
- mem_busy=1 for 3 cycles with exc_m=5 held -> cp0_req appears 1 cycle after mem_busy falls; reset asserted in COMMIT -> next cycle all outputs 0, with no redirect.
